// File: rtl/gray_link_pkg.sv
// rtl/gray_link_pkg.sv - shared types and defaults for the gray link scheduler
package gray_link_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/gray_link_sched_if.sv
// rtl/gray_link_sched_if.sv - requester, result and serial-monitor signals of the scheduler
interface gray_link_sched_if #(
  parameter int WIDTH = 5
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  logic             out_ready;
  logic             ser_en;
  logic             ser_bit;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_id, ser_en, ser_bit, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id, ser_en, ser_bit, busy
  );
endinterface

// File: rtl/gray_link_rr_arb.sv
// rtl/gray_link_rr_arb.sv - two-way round-robin arbiter with one-hot grant
module gray_link_rr_arb
  import gray_link_pkg::*;
(
  input  logic       en,
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // On a tie the requester that did not win last time goes first.
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/gray_link_sched.sv
// rtl/gray_link_sched.sv - round-robin front-end sharing one serial gray-to-binary path
// Optional GRAY_LINK_BYPASS_EN adds a per-word bypass input that skips the conversion.
module gray_link_sched
  import gray_link_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic clk,
  input logic rst_n,
`ifdef GRAY_LINK_BYPASS_EN
  input logic bypass,
`endif
  gray_link_sched_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             acc_q;
  req_id_t          id_q;
  req_id_t          last_grant_q;
  logic [1:0]       grant;
  logic             bin_bit;
`ifdef GRAY_LINK_BYPASS_EN
  logic             byp_q;
`endif

  // Gating with rst_n keeps ready low for the whole reset window.
  gray_link_rr_arb u_arb (
    .en         (rst_n && (state == S_IDLE)),
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    bin_bit = acc_q ^ shift_q[WIDTH-1];
`ifdef GRAY_LINK_BYPASS_EN
    if (byp_q) bin_bit = shift_q[WIDTH-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      shift_q      <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef GRAY_LINK_BYPASS_EN
      byp_q        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant != 2'b00) begin
            shift_q      <= grant[1] ? bus.req1_data : bus.req0_data;
            id_q         <= grant[1];
            last_grant_q <= grant[1];
            cnt_q        <= '0;
            acc_q        <= 1'b0;
`ifdef GRAY_LINK_BYPASS_EN
            byp_q        <= bypass;
`endif
            state        <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_q   <= bin_bit;
          res_q   <= {res_q[WIDTH-2:0], bin_bit};
          shift_q <= {shift_q[WIDTH-2:0], 1'b0};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.out_valid  = (state == S_DONE);
  assign bus.out_data   = res_q;
  assign bus.out_id     = id_q;
  assign bus.ser_en     = (state == S_SHIFT);
  assign bus.ser_bit    = shift_q[WIDTH-1];
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_gray_link_sched.sv
// tb/tb_gray_link_sched.sv - directed self-checking bench for gray_link_sched
module tb_gray_link_sched;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef GRAY_LINK_BYPASS_EN
  logic bypass = 1'b0;
`endif
  int   n_total = 0;
  int   n_pass = 0;

  gray_link_sched_if #(.WIDTH(W)) bus ();

  gray_link_sched #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef GRAY_LINK_BYPASS_EN
    .bypass(bypass),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests one word, checks the grant, serial stream and result; leaves the DUT in DONE
  // unless out_ready is high, in which case it also checks the return to IDLE.
  task automatic run_word(input logic id, input logic [W-1:0] gray, input logic [W-1:0] exp);
    logic got;
    got = 1'b0;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_data = gray; end
    else    begin bus.req0_valid = 1'b1; bus.req0_data = gray; end
    #1;
    for (int i = 0; i < 4 && !got; i++) begin
      got = id ? bus.req1_ready : bus.req0_ready;
      if (!got) tick();
    end
    check("grant", 32'(got), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("ser_en", 32'(bus.ser_en), 32'd1);
      check("ser_bit", 32'(bus.ser_bit), 32'(gray[W-1-i]));
      tick();
    end
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("out_data", 32'(bus.out_data), 32'(exp));
    check("out_id", 32'(bus.out_id), 32'(id));
    if (bus.out_ready) begin
      tick();
      check("idle_after", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.out_ready  = 1'b1;

    do_reset();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_ready1", 32'(bus.req1_ready), 32'd0);

    run_word(1'b0, 5'b11010, 5'b10011);
    run_word(1'b0, 5'b00000, 5'b00000);
    run_word(1'b0, 5'b10000, 5'b11111);
    run_word(1'b0, 5'b11111, 5'b10101);

    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 5'b00001;
    bus.req1_valid = 1'b1; bus.req1_data = 5'b00011;
    for (int k = 0; k < 4; k++) begin
      logic exp_id;
      exp_id = 1'(k % 2);
      #1;
      check("tie_ready0", 32'(bus.req0_ready), 32'(!exp_id));
      check("tie_ready1", 32'(bus.req1_ready), 32'(exp_id));
      tick();
      check("tie_no_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
      repeat (W) tick();
      check("tie_valid", 32'(bus.out_valid), 32'd1);
      check("tie_data", 32'(bus.out_data), exp_id ? 32'h02 : 32'h01);
      check("tie_id", 32'(bus.out_id), 32'(exp_id));
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    bus.out_ready = 1'b0;
    run_word(1'b1, 5'b00011, 5'b00010);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data", 32'(bus.out_data), 32'h02);
      check("bp_id", 32'(bus.out_id), 32'd1);
      check("bp_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release", 32'(bus.busy), 32'd0);

    bus.req0_valid = 1'b1; bus.req0_data = 5'b11010;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    check("mid_shift", 32'(bus.ser_en), 32'd1);
    rst_n = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 5'b01100;
    #1;
    check("rst_no_ready", 32'(bus.req1_ready), 32'd0);
    tick();
    check("rst_idle_busy", 32'(bus.busy), 32'd0);
    check("rst_idle_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    run_word(1'b1, 5'b01100, 5'b01000);

`ifdef GRAY_LINK_BYPASS_EN
    bypass = 1'b1;
    run_word(1'b0, 5'b11010, 5'b11010);
    bypass = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/gray_link_sched.md
Name: gray_link_sched

Overview:
Round-robin scheduler that shares one serial gray-to-binary conversion path between two requesters. Each granted request follows the same sequence:
- Parallel-load the gray word.
- Shift it out MSB-first, one bit per clk.
- Convert it serially to binary.
- Deserialize the result into a parallel register.
- Present the result with a valid/ready handshake.

The block is the sequencing front-end for the team's PISO → gray/bin FSM → SIPO serial link. It supplies the load/shift control and the arbitration between requesters.

Parameters:
- WIDTH, 5, word width in bits (gray in, binary out); legal values are 2..16.
- CNT_W, $clog2(WIDTH+1), width of the bit counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- req0_valid  in  1  requester 0 has a gray word.
- req0_data  in  WIDTH  requester 0 gray word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 has a gray word.
- req1_data  in  WIDTH  requester 1 gray word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- out_valid  out  1  converted binary word is available.
- out_data  out  WIDTH  binary result.
- out_id  out  1  index of the requester that owns out_data.
- out_ready  in  1  consumer accepts out_data.
- ser_en  out  1  a serial bit is on ser_bit this cycle (shift phase).
- ser_bit  out  1  gray bit currently being shifted (MSB first).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, SHIFT, DONE. Reset forces IDLE.
- Reset values:
  - all ready and valid outputs 0;
  - out_data 0, out_id 0;
  - shift register 0, bit counter 0, conversion accumulator 0;
  - last_grant 1, so requester 0 wins the first tie.
- rst_n low mid-operation: the word in flight is discarded and the block is in IDLE on the next cycle. No ready pulse is issued while rst_n is low.
- IDLE:
  - If any reqN_valid is high, grant exactly one requester. reqN_ready is combinational (state==IDLE && grant==N).
  - On the grant: load reqN_data into the shift register, latch the id, clear the counter and accumulator, then go to SHIFT.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the requester != last_grant wins.
  - last_grant updates only on a grant.
  - A requester that drops valid before being granted is not served; no ready is given to it.
- SHIFT (exactly WIDTH cycles):
  - ser_en=1 and ser_bit = shift register MSB.
  - Binary bit b = acc ^ ser_bit. acc <= b.
  - Result register <= {result[WIDTH-2:0], b}.
  - Shift register shifts left, filling with 0. Counter increments.
  - When counter == WIDTH-1, go to DONE.
- DONE:
  - out_valid=1; out_data and out_id are held stable.
  - On out_ready=1, go to IDLE; the next grant can occur in that following IDLE cycle.
  - No new request is accepted while in SHIFT or DONE, so reqN_ready stays 0.
- Latency and throughput:
  - Grant at cycle T gives out_valid at cycle T+WIDTH+1.
  - Minimum period is WIDTH+2 cycles per word (grant + WIDTH shift cycles + one DONE cycle with out_ready=1).
- Arithmetic: b[i] = b[i+1] ^ g[i] with b[WIDTH] = 0. No width growth; all registers are WIDTH bits.

Optional Feature:
- GRAY_LINK_BYPASS_EN defined:
  - adds input port `bypass` (1 bit), sampled at grant and held for that word;
  - when the sampled value is 1, b = ser_bit (no XOR), so out_data equals the raw input word;
  - latency is unchanged.
- GRAY_LINK_BYPASS_EN undefined: the port is absent and conversion is always performed.

Decomposition:
- Shared package gray_link_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - localparam for the default WIDTH;
  - requester-id typedef.
- One natural sub-module: gray_link_rr_arb, a 2-way round-robin arbiter. Inputs are the valids, last_grant and an enable; outputs are a one-hot grant. Sequencing, shift and convert stay in the top module.

Test Plan:
- Reset state: rst_n=0 for 2 cycles → out_valid=0, busy=0, out_data=0, req0_ready=req1_ready=0.
- Single conversion: req0 only, data 5'b11010, out_ready=1 →
  - req0_ready pulses at T;
  - ser_bit reads 1,1,0,1,0 over T+1..T+5;
  - out_valid at T+6 with out_data=5'b10011 and out_id=0.
- Boundary words: gray 5'b00000 → 5'b00000; gray 5'b10000 → 5'b11111; gray 5'b11111 → 5'b10101.
- Tie and fairness: both requesters held valid with req0=5'b00001 and req1=5'b00011 → grants alternate 0,1,0,1; results are 5'b00001 (id 0) and 5'b00010 (id 1).
- Backpressure: out_ready=0 for 10 cycles while in DONE → out_valid, out_data and out_id stay stable, both readys stay 0, busy=1. Raising out_ready gives IDLE next cycle.
- Reset mid-SHIFT: rst_n=0 on the third shift cycle → the next cycle is IDLE with out_valid=0. A fresh req1 word 5'b01100 is then converted correctly to 5'b01000.
  - With GRAY_LINK_BYPASS_EN defined and bypass=1: 5'b11010 → 5'b11010.
